// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// rippling the carry through a register between chunks.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             msb_cin;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk MSB recovered from the MSB sum bit; works for CHUNK=1 too.
        msb_cin   = chunk_res[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1; Cin is deliberately dropped in that mode.
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub | Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                    end
                end
                carry_d = chunk_res[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = msb_cin ^ chunk_res[CHUNK];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (8/8, 16/4, 32/1) checked against an
// arithmetic reference model with directed and randomized operations.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  start = '0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        cin_in = 1'b0;
    logic        sub_in = 1'b0;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start[0]), .A(a_in[7:0]), .B(b_in[7:0]),
        .Cin(cin_in), .Sub(sub_in), .busy(busy8), .done(done8), .Sum(sum8),
        .Cout(cout8), .Ovf(ovf8)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .rst(rst), .start(start[1]), .A(a_in[15:0]), .B(b_in[15:0]),
        .Cin(cin_in), .Sub(sub_in), .busy(busy16), .done(done16), .Sum(sum16),
        .Cout(cout16), .Ovf(ovf16)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_w32 (
        .clk(clk), .rst(rst), .start(start[2]), .A(a_in), .B(b_in),
        .Cin(cin_in), .Sub(sub_in), .busy(busy32), .done(done32), .Sum(sum32),
        .Cout(cout32), .Ovf(ovf32)
    );

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 16 : 32;
    endfunction

    function automatic int chunks_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 32;
    endfunction

    // Reference: whole-word arithmetic; overflow from operand/result sign bits.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub);
        logic [63:0] mask, am, bm, full, s;
        logic        c, sa, sb, ss, co, ov;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'd0, a} & mask;
        bm   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        c    = sub ? 1'b1 : cin;
        full = am + bm + {63'd0, c};
        s    = full & mask;
        co   = full[w];
        sa   = am[w-1];
        sb   = bm[w-1];
        ss   = s[w-1];
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, s[31:0]};
    endfunction

    task automatic get_out(input int k, output logic d, output logic bz, output logic [31:0] s,
                           output logic co, output logic ov);
        case (k)
            0: begin d = done8;  bz = busy8;  s = {24'd0, sum8};  co = cout8;  ov = ovf8;  end
            1: begin d = done16; bz = busy16; s = {16'd0, sum16}; co = cout16; ov = ovf16; end
            default: begin d = done32; bz = busy32; s = sum32; co = cout32; ov = ovf32; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input logic eo, input string tag);
        logic        d, bz, co, ov;
        logic [31:0] s;
        int          lat;
        int          n;
        n = chunks_of(k);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = cin; sub_in = sub; start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom); sub_in = 1'($urandom);
        get_out(k, d, bz, s, co, ov);
        check({tag, "_busy"}, 32'(bz), 32'd1);
        lat = 0;
        for (int c = 1; c <= n + 4; c++) begin
            @(posedge clk);
            #1;
            get_out(k, d, bz, s, co, ov);
            if (d) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(n));
        check({tag, "_sum"}, s, es);
        check({tag, "_cout"}, 32'(co), 32'(ec));
        check({tag, "_ovf"}, 32'(ov), 32'(eo));
        check({tag, "_busy_at_done"}, 32'(bz), 32'd0);
        @(posedge clk);
        #1;
        get_out(k, d, bz, s, co, ov);
        check({tag, "_done_pulse"}, 32'(d), 32'd0);
        check({tag, "_sum_hold"}, s, es);
    endtask

    task automatic run_rand(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input string tag);
        logic [33:0] r;
        r = ref_model(width_of(k), a, b, cin, sub);
        run_op(k, a, b, cin, sub, r[31:0], r[32], r[33], tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        d, bz, co, ov;
        logic [31:0] s;
        logic [33:0] r;
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic        bc [4];
        logic        bs [4];

        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            get_out(k, d, bz, s, co, ov);
            check("reset_busy", 32'(bz), 32'd0);
            check("reset_done", 32'(d), 32'd0);
            check("reset_sum", s, 32'd0);
            check("reset_flags", {30'd0, co, ov}, 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "ffff_plus_1");
        run_op(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "signed_ovf");
        run_op(1, 32'h0003, 32'h0005, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, "sub_ignores_cin");
        run_op(1, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_op(0, 32'h0080, 32'h0080, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1, "w8_neg_ovf");
        run_op(2, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "w32_cin_ripple");

        // Back-to-back with start held high and garbage inputs during RUN.
        for (int j = 0; j < 4; j++) begin
            ba[j] = $urandom; bb[j] = $urandom; bc[j] = 1'($urandom); bs[j] = 1'($urandom);
        end
        @(negedge clk);
        a_in = ba[0]; b_in = bb[0]; cin_in = bc[0]; sub_in = bs[0]; start[1] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                get_out(1, d, bz, s, co, ov);
                check("b2b_busy", 32'(bz), 32'd1);
                check("b2b_no_done", 32'(d), 32'd0);
                a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom); sub_in = 1'($urandom);
            end
            @(negedge clk);
            get_out(1, d, bz, s, co, ov);
            r = ref_model(16, ba[j], bb[j], bc[j], bs[j]);
            check("b2b_done", 32'(d), 32'd1);
            check("b2b_sum", s, r[31:0]);
            check("b2b_flags", {30'd0, co, ov}, {30'd0, r[32], r[33]});
            if (j < 3) begin
                a_in = ba[j+1]; b_in = bb[j+1]; cin_in = bc[j+1]; sub_in = bs[j+1];
            end else begin
                start[1] = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        get_out(1, d, bz, s, co, ov);
        check("b2b_end_idle", {30'd0, d, bz}, 32'd0);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        a_in = 32'hFFFF; b_in = 32'hFFFF; cin_in = 1'b1; sub_in = 1'b0; start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        get_out(1, d, bz, s, co, ov);
        check("abort_busy", 32'(bz), 32'd0);
        check("abort_done", 32'(d), 32'd0);
        check("abort_sum", s, 32'd0);
        check("abort_flags", {30'd0, co, ov}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            get_out(1, d, bz, s, co, ov);
            check("abort_no_done", 32'(d), 32'd0);
        end
        run_op(1, 32'h1234, 32'h1111, 1'b1, 1'b0, 32'h2346, 1'b0, 1'b0, "after_abort");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 4))
                    0: ra = 32'hFFFFFFFF;
                    1: rb = 32'h7FFFFFFF;
                    2: ra = 32'h80000000;
                    default: ;
                endcase
                run_rand(k, ra, rb, 1'($urandom), 1'($urandom), $sformatf("rand_k%0d_%0d", k, i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be a multiple of CHUNK, N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin an operation; sampled only when busy=0.
REQ-006 SHALL have port A, input, WIDTH: first operand, latched on accepted start.
REQ-007 SHALL have port B, input, WIDTH: second operand, latched on accepted start.
REQ-008 SHALL have port Cin, input, 1: carry-in, latched on accepted start; ignored when Sub=1.
REQ-009 SHALL have port Sub, input, 1: mode, latched on accepted start; 0 = A+B+Cin, 1 = A-B (A + ~B + 1).
REQ-010 SHALL have port busy, output, 1: high while chunks are being processed.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking valid results.
REQ-012 SHALL have port Sum, output, WIDTH: result, low WIDTH bits.
REQ-013 SHALL have port Cout, output, 1: carry out of MSB (borrow-not when Sub=1).
REQ-014 SHALL have port Ovf, output, 1: two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-016 SHALL accept start when busy=0 (IDLE or DONE): latch A, B (inverted if Sub), carry seed (Cin, or 1 if Sub), clear chunk index, enter RUN.
REQ-017 SHALL in RUN, per cycle, add chunk i of latched operands plus the registered carry, write CHUNK bits into Sum[i*CHUNK +: CHUNK], register the chunk carry, increment i.
REQ-018 SHALL, on the edge processing chunk N-1, enter DONE and make Sum, Cout, Ovf final; latency from start-accept edge to done=1 is exactly N cycles.
REQ-019 SHALL compute Ovf = carry into MSB XOR carry out of MSB of the final chunk.
REQ-020 SHALL leave DONE after one cycle: to RUN if start=1 that cycle (back-to-back), else IDLE.
REQ-021 SHALL hold Sum, Cout, Ovf stable from DONE until the next accepted start; Sum bits of unprocessed chunks are don't-care while busy=1.
REQ-022 SHALL ignore start and all operand/mode inputs while busy=1; input changes during RUN SHALL NOT affect the result.
REQ-023 SHALL treat the chunk index as log2(N)-wide (min 1 bit) with no wrap beyond N-1; N=1 SHALL give RUN for one cycle.

Reset
REQ-024 SHALL on rst=1, asynchronously, force state IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0, chunk index 0, internal carry 0.
REQ-025 SHALL abort any operation in progress on reset, producing no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-026 SHALL cover: WIDTH=16, CHUNK=4, A=16'hFFFF, B=16'h0001, Cin=0, Sub=0 -> done 4 cycles after accept, Sum=16'h0000, Cout=1, Ovf=0.
REQ-027 SHALL cover: A=16'h7FFF, B=16'h0001, Sub=0, Cin=0 -> Sum=16'h8000, Cout=0, Ovf=1.
REQ-028 SHALL cover: A=16'h0003, B=16'h0005, Sub=1, Cin=1 -> Sum=16'hFFFE, Cout=0, Ovf=0 (Cin ignored).
REQ-029 SHALL cover: start held high continuously with new operands each DONE cycle -> done every 5 cycles, each result matches operands latched at its accept; operand changes mid-RUN have no effect.
REQ-030 SHALL cover: rst pulsed on cycle 2 of RUN -> busy, done, Sum, Cout, Ovf all 0 immediately, no done pulse; next start A=16'h1234, B=16'h1111, Cin=1 -> Sum=16'h2346.
REQ-031 SHALL cover: randomized A, B, Cin, Sub across WIDTH/CHUNK of 8/8, 16/4, 32/1, compared to a reference model (Sum, Cout, Ovf, latency N).
